// File: rtl/skeeball_pkg.sv
// Shared definitions for the skeeball game blocks.
//  - game_state_e : 2-bit encoding of the game state machine's state
//  - NUM_BALLS_DEFAULT : balls per game, shared with the score logic
//  - timing defaults for the trigger generator
package skeeball_pkg;

  typedef enum logic [1:0] {
    ST_MENU   = 2'b00,
    ST_PLAY   = 2'b01,
    ST_FINISH = 2'b10,
    ST_SCORE  = 2'b11
  } game_state_e;

  localparam int NUM_BALLS_DEFAULT      = 9;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;
  localparam int PLAY_TIMEOUT_DEFAULT   = 50000000;
  localparam int FINISH_CYCLES_DEFAULT  = 150000000;

endpackage

// File: rtl/skeeball_debounce.sv
// Synchroniser, debouncer and rising-edge detector for one raw switch.
//  clk     in  system clock
//  rst_n   in  asynchronous active-low reset
//  raw_i   in  raw asynchronous switch, active-high
//  pulse_o out one-cycle pulse when the debounced level goes 0 -> 1
// The debounced level only follows the synchronised input after it has
// disagreed with the current level for DEBOUNCE_CYCLES consecutive samples.
module skeeball_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic pulse_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;
    if (sync2_q == level_q) begin
      // Any sample agreeing with the current level restarts the stability window.
      cnt_d = '0;
    end else if (cnt_q >= CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt_d   = '0;
      level_d = sync2_q;
      pulse_d = sync2_q;  // only rising edges produce a press
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/skeeball_trigger_gen.sv
// Generates the single-cycle advance request for the skeeball game FSM.
//  clk         in  system clock
//  rst_n       in  asynchronous active-low reset
//  start_btn   in  raw start button (async, active-high)
//  ball_sensor in  raw ball-return switch (async, active-high)
//  state       in  current game state (00 menu, 01 play, 10 finish, 11 score)
//  trigger     out registered one-cycle advance request
//  balls_left  out remaining balls in the current game
//  ball_event  out one-cycle pulse per accepted ball
// A single phase timer serves as the idle timer while playing and as the
// hold timer on the finish screen; it restarts on every observed state
// change (the change cycle counts as cycle 1) and on every accepted ball.
module skeeball_trigger_gen
  import skeeball_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int NUM_BALLS       = NUM_BALLS_DEFAULT,
  parameter int PLAY_TIMEOUT    = PLAY_TIMEOUT_DEFAULT,
  parameter int FINISH_CYCLES   = FINISH_CYCLES_DEFAULT
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start_btn,
  input  logic                             ball_sensor,
  input  logic [1:0]                       state,
  output logic                             trigger,
  output logic [$clog2(NUM_BALLS+1)-1:0]   balls_left,
  output logic                             ball_event
);

  localparam int BW   = $clog2(NUM_BALLS + 1);
  localparam int TMAX = (PLAY_TIMEOUT > FINISH_CYCLES) ? PLAY_TIMEOUT : FINISH_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  logic          btn_pulse, ball_pulse;
  logic          trigger_q, trigger_d;
  logic          ball_event_q, ball_event_d;
  logic [BW-1:0] balls_q, balls_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          lock_q, lock_d;
  logic [1:0]    lock_state_q, lock_state_d;
  logic [1:0]    state_prev_q;
  logic          state_changed;
  logic          blocked;

  skeeball_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_i  (start_btn),
    .pulse_o(btn_pulse)
  );

  skeeball_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ball_db (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_i  (ball_sensor),
    .pulse_o(ball_pulse)
  );

  always_comb begin
    trigger_d     = 1'b0;
    ball_event_d  = 1'b0;
    balls_d       = balls_q;
    lock_d        = lock_q;
    lock_state_d  = lock_state_q;
    state_changed = (state != state_prev_q);
    // trigger_q term guarantees no back-to-back triggers even if the state
    // flips on the very cycle after a request.
    blocked       = trigger_q || (lock_q && (state == lock_state_q));

    if (state_changed) begin
      timer_d = TW'(1);
    end else if (timer_q == TW'(TMAX)) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + TW'(1);
    end

    case (state)
      ST_MENU: begin
        if (btn_pulse && !blocked) begin
          trigger_d = 1'b1;
          balls_d   = BW'(NUM_BALLS);
        end
      end
      ST_PLAY: begin
        if (ball_pulse && (balls_q != '0)) begin
          balls_d      = balls_q - BW'(1);
          ball_event_d = 1'b1;
          timer_d      = TW'(1);
          if ((balls_q == BW'(1)) && !blocked) begin
            trigger_d = 1'b1;
          end
        end else if (!state_changed && (timer_q >= TW'(PLAY_TIMEOUT - 1)) && !blocked) begin
          trigger_d = 1'b1;
          balls_d   = '0;
        end
      end
      ST_FINISH: begin
        // Button and timer expiry share one request bit, so a coincidence
        // still yields a single trigger.
        if (!blocked && (btn_pulse ||
            (!state_changed && (timer_q >= TW'(FINISH_CYCLES - 1))))) begin
          trigger_d = 1'b1;
        end
      end
      ST_SCORE: begin
        if (btn_pulse && !blocked) begin
          trigger_d = 1'b1;
        end
      end
      default: begin
        // unknown state: no request
      end
    endcase

    if (trigger_d) begin
      lock_d       = 1'b1;
      lock_state_d = state;
    end else if (state_changed) begin
      lock_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trigger_q    <= 1'b0;
      ball_event_q <= 1'b0;
      balls_q      <= '0;
      timer_q      <= '0;
      lock_q       <= 1'b0;
      lock_state_q <= ST_MENU;
      state_prev_q <= ST_MENU;
    end else begin
      trigger_q    <= trigger_d;
      ball_event_q <= ball_event_d;
      balls_q      <= balls_d;
      timer_q      <= timer_d;
      lock_q       <= lock_d;
      lock_state_q <= lock_state_d;
      state_prev_q <= state;
    end
  end

  assign trigger    = trigger_q;
  assign ball_event = ball_event_q;
  assign balls_left = balls_q;

endmodule
